// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: instruction width, bubble encoding and fetch FSM states.
package pipeline_pkg;

  localparam int unsigned InstrWidth = 32;

  // addi x0, x0, 0
  localparam logic [InstrWidth-1:0] NopInstrDefault = 32'h0000_0013;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StWait  = 2'd1,
    StDrop  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc, pc+4} holding buffer for a response that decode cannot take yet.
module fetch_skid_buf
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  drain,
  input  logic [InstrWidth-1:0] in_instr,
  input  logic [31:0]           in_pc,
  input  logic [31:0]           in_pc4,
  output logic                  full,
  output logic [InstrWidth-1:0] out_instr,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_pc4
);

  logic                  full_q;
  logic [InstrWidth-1:0] instr_q;
  logic [31:0]           pc_q;
  logic [31:0]           pc4_q;

  // Load wins over drain so a same-cycle refill keeps the entry occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
    end else if (clear) begin
      full_q <= 1'b0;
    end else if (load) begin
      full_q  <= 1'b1;
      instr_q <= in_instr;
      pc_q    <= in_pc;
      pc4_q   <= in_pc4;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end

  assign full      = full_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;
  assign out_pc4   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem handshake, skid buffer
// and IF/ID pipeline register.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0]           RESET_PC  = 32'h0000_0000,
  parameter logic [InstrWidth-1:0] NOP_INSTR = NopInstrDefault
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [31:0]           PCTargetE,
  output logic                  ImemReq,
  output logic [31:0]           ImemAddr,
  input  logic                  ImemReady,
  input  logic                  ImemRValid,
  input  logic [InstrWidth-1:0] ImemRData,
  output logic [InstrWidth-1:0] InstrD,
  output logic [31:0]           PCD1,
  output logic [31:0]           PCPlus4D1,
  output logic                  ValidD
);

  fetch_state_e          state_q, state_d;
  logic [31:0]           pcf_q, pcf_d;
  logic [31:0]           req_pc_q, req_pc_d;
  logic [31:0]           req_pc_plus4;
  logic [InstrWidth-1:0] instr_q, instr_d;
  logic [31:0]           pcd_q, pcd_d;
  logic [31:0]           pcp4d_q, pcp4d_d;
  logic                  valid_q, valid_d;

  logic                  take, resp, fire;
  logic                  skid_full, skid_full_next;
  logic                  skid_clear, skid_load, skid_drain;
  logic [InstrWidth-1:0] skid_instr;
  logic [31:0]           skid_pc, skid_pc4;

  assign req_pc_plus4 = req_pc_q + 32'd4;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .reset    (reset),
    .clear    (skid_clear),
    .load     (skid_load),
    .drain    (skid_drain),
    .in_instr (ImemRData),
    .in_pc    (req_pc_q),
    .in_pc4   (req_pc_plus4),
    .full     (skid_full),
    .out_instr(skid_instr),
    .out_pc   (skid_pc),
    .out_pc4  (skid_pc4)
  );

  always_comb begin
    take       = !StallD && !FlushD;
    resp       = (state_q == StWait) && ImemRValid;
    skid_clear = PCSrcE;
    skid_drain = skid_full && take;
    skid_load  = resp && !PCSrcE && !(take && !skid_full);
    if (PCSrcE)          skid_full_next = 1'b0;
    else if (skid_load)  skid_full_next = 1'b1;
    else if (skid_drain) skid_full_next = 1'b0;
    else                 skid_full_next = skid_full;
    // Only request when the buffer will be free, so any response always has a home.
    ImemReq  = !reset && !PCSrcE && !skid_full_next && ((state_q == StFetch) || resp);
    ImemAddr = pcf_q;
    fire     = ImemReq && ImemReady;
  end

  always_comb begin
    state_d  = state_q;
    pcf_d    = pcf_q;
    req_pc_d = req_pc_q;
    if (fire) begin
      pcf_d    = pcf_q + 32'd4;
      req_pc_d = pcf_q;
    end
    unique case (state_q)
      StFetch: if (fire) state_d = StWait;
      StWait:  if (ImemRValid) state_d = fire ? StWait : StFetch;
      StDrop:  if (ImemRValid) state_d = StFetch;
      default: state_d = StFetch;
    endcase
    if (PCSrcE) begin
      pcf_d   = PCTargetE & 32'hFFFF_FFFC;
      state_d = ((state_q != StFetch) && !ImemRValid) ? StDrop : StFetch;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4d_d = pcp4d_q;
    valid_d = valid_q;
    if (PCSrcE || FlushD || !StallD) begin
      instr_d = NOP_INSTR;
      pcd_d   = '0;
      pcp4d_d = '0;
      valid_d = 1'b0;
      if (!PCSrcE && !FlushD) begin
        if (skid_full) begin
          instr_d = skid_instr;
          pcd_d   = skid_pc;
          pcp4d_d = skid_pc4;
          valid_d = 1'b1;
        end else if (resp) begin
          instr_d = ImemRData;
          pcd_d   = req_pc_q;
          pcp4d_d = req_pc_plus4;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StFetch;
      pcf_q    <= RESET_PC;
      req_pc_q <= '0;
      instr_q  <= NOP_INSTR;
      pcd_q    <= '0;
      pcp4d_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcf_q    <= pcf_d;
      req_pc_q <= req_pc_d;
      instr_q  <= instr_d;
      pcd_q    <= pcd_d;
      pcp4d_q  <= pcp4d_d;
      valid_q  <= valid_d;
    end
  end

  assign InstrD    = instr_q;
  assign PCD1      = pcd_q;
  assign PCPlus4D1 = pcp4d_q;
  assign ValidD    = valid_q;

endmodule
